sqrt_issue_ctrl: RTL and testbench
==================================

Name: sqrt_issue_ctrl

Overview:
Upstream sequencer for behaviour_sqrt. It accepts 8-bit operands over a valid/ready interface and buffers them in a small FIFO. Each operand is presented to the square-root stage on that stage's dt_i, and enb_i is held high for a fixed settle window. The result is then captured and returned downstream with its operand over a valid/ready interface. The square-root stage has no done flag, so completion is defined purely by the settle count.

Parameters:
DW, 8, operand/result width
SETTLE, 15, cycles enb is held high per operand before the result is captured (must be >= 1)
FIFO_DEPTH, 4, operand FIFO entries (power of 2, >= 2)

Ports:
clk_i  in  1  clock, all state on rising edge
rstn_i  in  1  reset, asynchronous, active-low
in_valid_i  in  1  operand valid
in_ready_o  out  1  FIFO not full
in_data_i  in  DW  operand
sq_dt_o  out  DW  to sqrt dt_i; current operand
sq_enb_o  out  1  to sqrt enb_i
sq_dt_i  in  DW  from sqrt dt_o
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
out_data_o  out  DW  operand belonging to the result
out_root_o  out  DW  captured root
err_o  out  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, cnt 0, sq_dt_o 0, sq_enb_o 0, out_valid_o 0, out_data_o 0, out_root_o 0, err_o 0. in_ready_o is 1 after reset.
- Push: when in_valid_i && in_ready_o, write in_data_i at the rising edge. in_ready_o = !full, a combinational function of the count only.
- Simultaneous push and pop on a non-empty, non-full FIFO: both happen and the count is unchanged.
- When full, in_ready_o is 0. There is no pass-through.
- Pointers wrap modulo FIFO_DEPTH. The count has width clog2(FIFO_DEPTH)+1.
- FSM:
  IDLE: if FIFO not empty, pop head into the op register, cnt<=0, go to WAIT. Otherwise stay.
  WAIT: sq_enb_o=1. cnt increments each cycle. On the edge where cnt==SETTLE-1: out_root_o<=sq_dt_i, out_data_o<=op, out_valid_o<=1, go to OUT.
  OUT: sq_enb_o=0, so the sqrt stage freezes. out_valid_o=1 and outputs are held stable. On out_ready_i: out_valid_o<=0, go to IDLE.
- sq_dt_o always equals the op register. It changes only on a pop edge.
- sq_enb_o is a registered output, high exactly during WAIT.
- Latency: for a push into an empty FIFO at edge t0, pop occurs at t1. sq_enb_o is high from t1 through t1+SETTLE. out_valid_o rises after edge t1+SETTLE, i.e. SETTLE+1 cycles after acceptance.
- Throughput: one result per SETTLE+2 cycles when out_ready_i is held high.
- out_ready_i low in OUT: the FSM waits indefinitely and the FIFO continues to accept operands until full.
- out_ready_i outside OUT is ignored.
- Reset mid-WAIT or mid-OUT: everything clears immediately. The in-flight and buffered operands are dropped.

Optional Feature:
SQRT_CHECK_EN.
- Defined: at capture, compute the reference floor(sqrt(op)) combinationally by a bounded loop over 0..2^(DW/2)-1. If it differs from sq_dt_i, set err_o. err_o stays set until reset.
- Undefined: err_o is tied to 0 and no checker logic is generated.

Decomposition:
- Package sqrt_pkg holds:
  - state_t enum {IDLE, WAIT, OUT};
  - DW_DEF=8;
  - SETTLE_DEF=15;
  - function isqrt_ref(DW-bit) for the checker and the bench.
- One sub-module, sqrt_op_fifo, a synchronous FIFO with DW/FIFO_DEPTH params, push/pop, full/empty, and the same clk_i/rstn_i.

Test Plan:
- Reset, then push 200 with out_ready_i=1. sq_dt_o=200, sq_enb_o high for 15 cycles, out_valid_o rises 16 cycles after acceptance with out_root_o=14, out_data_o=200.
- Push 0 and 255 back-to-back. Results appear in order: (0,0) then (255,15), with 17 cycles between out_valid_o pulses.
- Hold out_ready_i=0 and push 6 operands. After 1 is popped and 4 are buffered, in_ready_o=0 and the 6th is stalled. sq_enb_o stays 0 in OUT. Release out_ready_i: all 5 complete in order, and the 6th is accepted once space frees.
- Sweep 0..255 with random out_ready_i stalls. Every out_root_o matches isqrt_ref(out_data_o), and outputs are stable while valid and not ready.
- Assert rstn_i low at cnt=7 in WAIT. All outputs are at reset values immediately, FIFO is empty, and the next push restarts with full 16-cycle latency.
- With SQRT_CHECK_EN, force sq_dt_i=3 for operand 100. err_o rises at capture and stays 1 until reset. Without the macro, err_o=0.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types, defaults and integer square-root reference for the sqrt issue controller
package sqrt_pkg;
  localparam int DW_DEF = 8;
  localparam int SETTLE_DEF = 15;
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
  function automatic logic [DW_DEF-1:0] isqrt_ref(input logic [DW_DEF-1:0] v);
    logic [DW_DEF-1:0] r;
    r = '0;
    for (int i = 0; i < 2 ** (DW_DEF / 2); i++)
      if (i * i <= int'(v)) r = DW_DEF'(i);
    return r;
  endfunction
endpackage

// File: rtl/sqrt_op_fifo.sv
// sqrt_op_fifo: synchronous operand FIFO with full/empty flags, pointers wrap modulo DEPTH
module sqrt_op_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/sqrt_issue_ctrl.sv
// sqrt_issue_ctrl: feeds buffered operands to the sqrt stage for a fixed settle window; SQRT_CHECK_EN adds a sticky root checker
module sqrt_issue_ctrl
  import sqrt_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic [DW-1:0] sq_dt_o,
  output logic          sq_enb_o,
  input  logic [DW-1:0] sq_dt_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [DW-1:0] out_root_o,
  output logic          err_o
);
  localparam int CW = $clog2(SETTLE + 1);
  state_t state, state_n;
  logic [DW-1:0] op, head;
  logic [CW-1:0] cnt;
  logic full, empty, pop, done;
  assign in_ready_o = !full;
  assign pop = state == IDLE && !empty;
  assign done = state == WAIT && cnt == CW'(SETTLE - 1);
  assign sq_dt_o = op;
  sqrt_op_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .push  (in_valid_i),
    .pop   (pop),
    .din   (in_data_i),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      out_data_o <= '0;
      out_root_o <= '0;
    end else begin
      state <= state_n;
      op <= pop ? head : op;
      cnt <= pop ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      out_root_o <= done ? sq_dt_i : out_root_o;
      out_data_o <= done ? op : out_data_o;
    end
  always_comb
    state_n = state == IDLE ? (empty ? IDLE : WAIT) :
              state == WAIT ? (done ? OUT : WAIT) :
              (out_ready_i ? IDLE : OUT);
  always_comb begin
    sq_enb_o = state == WAIT;
    out_valid_o = state == OUT;
  end
`ifdef SQRT_CHECK_EN
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) err_o <= 1'b0;
    else if (done && isqrt_ref(op) != sq_dt_i) err_o <= 1'b1;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sqrt_issue_ctrl.sv
// tb_sqrt_issue_ctrl: directed bench with a transaction-level model of the issue controller and a settle-sensitive sqrt stand-in
module tb_sqrt_issue_ctrl;
  localparam int SETTLE = 15;
  localparam int FD = 4;
  logic clk = 0, rstn = 0, in_valid = 0, out_ready = 0;
  logic in_ready, sq_enb, out_valid, err;
  logic [7:0] in_data = 0, sq_dt_o, sq_dt_i, out_data, out_root;
  int vec = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;

  sqrt_issue_ctrl #(.DW(8), .SETTLE(SETTLE), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .sq_dt_o(sq_dt_o), .sq_enb_o(sq_enb), .sq_dt_i(sq_dt_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_root_o(out_root), .err_o(err)
  );

  function automatic logic [7:0] isq(input logic [7:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 8'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sqrt stand-in: root is only valid once enb has been high long enough
  int enb_cnt;
  bit force_bad = 0;
  always @(posedge clk or negedge rstn)
    if (!rstn) enb_cnt <= 0;
    else enb_cnt <= sq_enb ? enb_cnt + 1 : 0;
  always_comb sq_dt_i = force_bad ? 8'd3 : (enb_cnt >= SETTLE - 1 ? isq(sq_dt_o) : 8'hEE);

  int q[$];
  int m_busy = 0;
  bit m_hold = 0, m_err = 0, m_acc = 0, prev_v = 0;
  logic [7:0] m_op = 0, m_od = 0, m_or = 0;
  int acc_cyc = 0, enb_cycles = 0;
  int r_cyc[$], r_root[$], r_data[$];

  always @(negedge rstn) begin
    q.delete();
    m_busy = 0; m_hold = 0; m_err = 0; m_acc = 0; prev_v = 0;
    m_op = 0; m_od = 0; m_or = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (rstn) begin
      m_acc = in_valid && q.size() < FD;
      if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hold = 1; m_od = m_op; m_or = sq_dt_i;
`ifdef SQRT_CHECK_EN
          if (sq_dt_i != isq(m_op)) m_err = 1;
`endif
        end
      end else if (q.size() > 0) begin
        m_op = 8'(q.pop_front());
        m_busy = SETTLE;
      end
      if (m_acc) begin
        q.push_back(int'(in_data));
        acc_cyc = cyc;
      end
    end
    #1;
    if (rstn) begin
      chk("in_ready", in_ready, q.size() < FD);
      chk("sq_enb", sq_enb, m_busy > 0);
      chk("sq_dt_o", sq_dt_o, m_op);
      chk("out_valid", out_valid, m_hold);
      chk("out_data", out_data, m_od);
      chk("out_root", out_root, m_or);
      chk("err", err, m_err);
      if (out_valid && !force_bad) chk("root_vs_ref", out_root, isq(out_data));
      if (sq_enb) enb_cycles++;
      if (out_valid && !prev_v) begin
        r_cyc.push_back(cyc); r_root.push_back(int'(out_root)); r_data.push_back(int'(out_data));
      end
      prev_v = out_valid;
    end
  end

  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk); in_valid = 1; in_data = d;
    do begin @(posedge clk); #2; n++; end while (!m_acc && n < 3000);
    in_valid = 0;
    if (!m_acc) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || m_busy > 0 || m_hold) && n < 6000) begin @(posedge clk); #2; n++; end
    chk("drain_timeout", n < 6000, 1);
  endtask

  task automatic clear_log();
    r_cyc.delete(); r_root.delete(); r_data.delete(); enb_cycles = 0;
  endtask

  bit rand_rdy = 0;
  always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sq_enb", sq_enb, 0);
    chk("rst_sq_dt", sq_dt_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_root", out_root, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    // single operand
    out_ready = 1; clear_log();
    push(8'd200);
    n = acc_cyc;
    drain();
    chk("t1_count", r_cyc.size(), 1);
    chk("t1_latency", r_cyc[0] - n, 16);
    chk("t1_root", r_root[0], 14);
    chk("t1_data", r_data[0], 200);
    chk("t1_enb_cycles", enb_cycles, 15);
    // back-to-back pair
    clear_log();
    push(8'd0); push(8'd255);
    drain();
    chk("t2_count", r_cyc.size(), 2);
    chk("t2_d0", r_data[0], 0);
    chk("t2_r0", r_root[0], 0);
    chk("t2_d1", r_data[1], 255);
    chk("t2_r1", r_root[1], 15);
    chk("t2_gap", r_cyc[1] - r_cyc[0], 17);
    // backpressure fills the FIFO
    clear_log(); out_ready = 0;
    for (int i = 0; i < 5; i++) push(8'(16 + i));
    @(negedge clk); in_valid = 1; in_data = 8'd21;
    repeat (25) @(negedge clk);
    chk("t3_full", in_ready, 0);
    chk("t3_enb_in_out", sq_enb, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_data, 16);
    out_ready = 1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!m_acc && n < 3000);
    in_valid = 0;
    chk("t3_sixth_accepted", m_acc, 1);
    drain();
    chk("t3_count", r_cyc.size(), 6);
    for (int i = 0; i < 6; i++) if (i < r_data.size()) chk("t3_order", r_data[i], 16 + i);
    // full sweep with random stalls
    clear_log(); rand_rdy = 1;
    for (int i = 0; i < 256; i++) push(8'(i));
    @(negedge clk); rand_rdy = 0; out_ready = 1;
    drain();
    chk("t4_count", r_cyc.size(), 256);
    for (int i = 0; i < 256; i++) if (i < r_data.size()) chk("t4_order", r_data[i], i);
    // reset mid-WAIT
    clear_log();
    push(8'd50); push(8'd60);
    n = 0;
    while (enb_cycles < 8 && n < 100) begin @(posedge clk); #2; n++; end
    @(negedge clk); rstn = 0; #1;
    chk("t5_sq_enb", sq_enb, 0);
    chk("t5_sq_dt", sq_dt_o, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_data", out_data, 0);
    @(negedge clk); rstn = 1;
    clear_log();
    push(8'd81);
    n = acc_cyc;
    drain();
    repeat (20) @(negedge clk);
    chk("t5_count", r_cyc.size(), 1);
    chk("t5_latency", r_cyc[0] - n, 16);
    chk("t5_data", r_data[0], 81);
    chk("t5_root", r_root[0], 9);
    // wrong root from the sqrt stage
    force_bad = 1;
    push(8'd100);
    drain();
    repeat (5) @(negedge clk);
`ifdef SQRT_CHECK_EN
    chk("t6_err_set", err, 1);
`else
    chk("t6_err_off", err, 0);
`endif
    force_bad = 0;
    push(8'd144);
    drain();
`ifdef SQRT_CHECK_EN
    chk("t6_err_sticky", err, 1);
`else
    chk("t6_err_still_off", err, 0);
`endif
    @(negedge clk); rstn = 0; #1;
    chk("t6_err_reset", err, 0);
    @(negedge clk); rstn = 1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
